// File: rtl/aud_pkg.sv
// Shared types and constants for the audio playback controller.
package aud_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRIME,
    ST_PLAY,
    ST_STOP
  } aud_state_e;

  localparam int LANES = 4;

  // Idle level for the PWM modulator: 2^(width-1).
  function automatic logic [31:0] midscale(input int width);
    return 32'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/aud_playback_ctrl_if.sv
// FIFO read port between the playback controller (master) and a first-word-fall-through FIFO (slave).
interface aud_playback_ctrl_if #(
  parameter int FIFO_DATA_WIDTH = 32
);
  logic [FIFO_DATA_WIDTH-1:0] fifo_rd_data;
  logic                       fifo_rd_en;
  logic                       fifo_empty;
  logic                       fifo_almost_empty;

  modport master (
    output fifo_rd_en,
    input  fifo_rd_data,
    input  fifo_empty,
    input  fifo_almost_empty
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_rd_data,
    output fifo_empty,
    output fifo_almost_empty
  );
endinterface

// File: rtl/aud_rate_div.sv
// Sample-rate divider: loadable down-counter that reloads itself and strobes tc_o when it hits zero.
module aud_rate_div #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic                 en_i,
  input  logic [DIV_WIDTH-1:0] reload_i,
  output logic                 tc_o
);
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;

  assign tc_o = en_i && (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = reload_i;
    end else if (en_i) begin
      cnt_d = tc_o ? reload_i : cnt_q - DIV_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/aud_playback_ctrl.sv
// Audio playback controller: pops 4-lane words from a FWFT FIFO and paces samples out at rate_div+1.
// Optional feature: define AUD_UNDERRUN_CNT_EN to add the saturating 16-bit underrun_count output.
module aud_playback_ctrl
  import aud_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int FIFO_DATA_WIDTH = 4 * DATA_WIDTH,
  parameter int DIV_WIDTH       = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stop,
  input  logic [DIV_WIDTH-1:0]   rate_div,
  aud_playback_ctrl_if.master    fifo,
  output logic [DATA_WIDTH-1:0]  sample,
  output logic                   sample_valid,
  output logic                   aud_en,
  output logic                   busy,
  output logic                   underrun
`ifdef AUD_UNDERRUN_CNT_EN
  ,
  output logic [15:0]            underrun_count
`endif
);
  localparam int                    LANE_W    = $clog2(LANES);
  localparam logic [DATA_WIDTH-1:0] MIDSCALE  = DATA_WIDTH'(midscale(DATA_WIDTH));
  localparam logic [LANE_W-1:0]     LAST_LANE = LANE_W'(LANES - 1);

  aud_state_e                 state_q, state_d;
  logic [DIV_WIDTH-1:0]       rate_q;
  logic [FIFO_DATA_WIDTH-1:0] word_q;
  logic [LANE_W-1:0]          lane_q;
  logic [DATA_WIDTH-1:0]      sample_q, sample_d, lane_data;
  logic                       sample_valid_q, underrun_q, underrun_d;
  logic                       tc, last_lane, rd_en, prime_load, latch_rate, div_en;

  aud_rate_div #(.DIV_WIDTH(DIV_WIDTH)) u_rate_div (
    .clk      (clk),
    .rst      (rst),
    .load_i   (prime_load),
    .en_i     (div_en),
    .reload_i (rate_q),
    .tc_o     (tc)
  );

  assign lane_data = word_q[int'(lane_q) * DATA_WIDTH +: DATA_WIDTH];
  assign last_lane = (lane_q == LAST_LANE);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start && !stop) state_d = ST_PRIME;
      ST_PRIME: if (stop) state_d = ST_IDLE;
                else if (!fifo.fifo_almost_empty && !fifo.fifo_empty) state_d = ST_PLAY;
      ST_PLAY:  if (tc && last_lane) begin
                  if (stop)                  state_d = ST_IDLE;
                  else if (fifo.fifo_empty)  state_d = ST_PRIME;
                end else if (stop) begin
                  state_d = ST_STOP;
                end
      ST_STOP:  if (tc && last_lane) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // The refill pop shares the edge that registers the lane-3 sample, so strobes never gap.
  always_comb begin
    rd_en      = 1'b0;
    prime_load = 1'b0;
    latch_rate = 1'b0;
    div_en     = 1'b0;
    underrun_d = 1'b0;
    unique case (state_q)
      ST_IDLE:  latch_rate = start && !stop;
      ST_PRIME: begin
        prime_load = !stop && !fifo.fifo_almost_empty && !fifo.fifo_empty;
        rd_en      = prime_load;
      end
      ST_PLAY: begin
        div_en = 1'b1;
        if (tc && last_lane && !stop) begin
          rd_en      = !fifo.fifo_empty;
          underrun_d = fifo.fifo_empty;
        end
      end
      ST_STOP:  div_en = 1'b1;
      default:  ;
    endcase

    sample_d = sample_q;
    if (tc) sample_d = lane_data;
    else if (state_d == ST_IDLE || state_d == ST_PRIME) sample_d = MIDSCALE;
  end

  // NOTE: data registers are reset too, so a restart after rst never sees stale lanes or rates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rate_q         <= '0;
      word_q         <= '0;
      lane_q         <= '0;
      sample_q       <= MIDSCALE;
      sample_valid_q <= 1'b0;
      underrun_q     <= 1'b0;
    end else begin
      if (latch_rate) rate_q <= rate_div;
      if (rd_en)      word_q <= fifo.fifo_rd_data;
      if (prime_load) lane_q <= '0;
      else if (tc)    lane_q <= lane_q + LANE_W'(1);
      sample_q       <= sample_d;
      sample_valid_q <= tc;
      underrun_q     <= underrun_d;
    end
  end

`ifdef AUD_UNDERRUN_CNT_EN
  logic [15:0] urun_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) urun_cnt_q <= '0;
    else if (underrun_d && urun_cnt_q != 16'hFFFF) urun_cnt_q <= urun_cnt_q + 16'd1;
  end

  assign underrun_count = urun_cnt_q;
`endif

  assign fifo.fifo_rd_en = rd_en;
  assign sample          = sample_q;
  assign sample_valid    = sample_valid_q;
  assign underrun        = underrun_q;
  assign busy            = (state_q != ST_IDLE);
  assign aud_en          = (state_q == ST_PLAY) || (state_q == ST_STOP);
endmodule
